hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-002 SHALL have port clk, input, 1, clock; reset rst, synchronous, active-high.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports id_rs1/id_rs2, input, 5, ID-stage source registers; id_uses_rs1/id_uses_rs2, input, 1, source valid.
REQ-005 SHALL have ports ex_rd, input, 5, EX destination; ex_is_load, input, 1, EX holds a load.
REQ-006 SHALL have port ex_redirect, input, 1, taken branch/jump resolved in EX.
REQ-007 SHALL have ports imem_req, imem_resp, dmem_req, dmem_resp, input, 1 each: one-cycle request and response pulses.
REQ-008 SHALL have ports pc_stall, if_id_stall, if_id_nop, id_ex_stall, id_ex_nop, ex_mem_stall, ex_mem_nop, mem_wb_stall, mem_wb_nop, output, 1 each: stall/nop controls for the PC and pipeline buffers.
REQ-009 SHALL have ports stall_cycles, loaduse_cnt, flush_cnt, output, CNT_W each, present only under HAZARD_PERF_EN.

Function
REQ-010 SHALL implement FSM states RUN, WAIT_I, WAIT_D, WAIT_ID, tracking outstanding imem/dmem requests.
REQ-011 SHALL count a request as outstanding when req=1 and resp=0 in the same cycle; a same-cycle resp means zero-latency completion with no wait state.
REQ-012 SHALL transition RUN->WAIT_I/WAIT_D/WAIT_ID per outstanding set; WAIT_ID->WAIT_I on dmem_resp, ->WAIT_D on imem_resp, ->RUN on both; WAIT_x->RUN on the matching resp.
REQ-013 SHALL, in any WAIT state, drive pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall=1 and mem_wb_nop=1 (bubble into WB); all other nops 0.
REQ-014 SHALL detect load-use in RUN: ex_is_load && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
REQ-015 SHALL, on load-use, drive pc_stall=1, if_id_stall=1, id_ex_nop=1, id_ex_stall=0 for exactly one cycle.
REQ-016 SHALL, on ex_redirect in RUN, drive if_id_nop=1 and id_ex_nop=1 with no stalls; redirect overrides load-use in the same cycle.
REQ-017 SHALL latch ex_redirect asserted during a WAIT state into redirect_pend and apply the REQ-016 flush in the first RUN cycle, then clear it.
REQ-018 SHALL suppress load-use detection in WAIT states and in the redirect_pend release cycle.
REQ-019 SHALL drive all outputs combinationally from state, redirect_pend and current inputs (zero latency).

Reset
REQ-020 SHALL, while rst=1, drive all *_nop=1 and all *_stall=0.
REQ-021 SHALL, on rst, set state=RUN, clear redirect_pend and outstanding tracking, and zero counters; rst mid-wait abandons the wait and later responses are ignored.

Configuration
REQ-022 SHALL compile the counters under macro HAZARD_PERF_EN; without it the counter ports and logic are absent and stall/nop behaviour is identical.
REQ-023 SHALL, with HAZARD_PERF_EN: stall_cycles +1 per WAIT or load-use cycle, loaduse_cnt +1 per load-use, flush_cnt +1 per applied flush; saturating at 2^CNT_W-1.

Structure
REQ-024 SHALL place enum hazard_state_t (RUN, WAIT_I, WAIT_D, WAIT_ID) in shared package rv32i_types.
REQ-025 SHALL use one sub-module hazard_perf_cnt (saturating counter, parameter CNT_W) instantiated per counter.

Verification
REQ-026 SHALL cover: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle pc_stall=1, if_id_stall=1, id_ex_nop=1; loaduse_cnt=1.
REQ-027 SHALL cover: ex_rd=0 load with id_rs1=0 -> no stall, no nop.
REQ-028 SHALL cover: dmem_req at t0, dmem_resp at t3 -> all stalls and mem_wb_nop high t0..t2, RUN at t3; stall_cycles=3.
REQ-029 SHALL cover: imem_req+dmem_req at t0, imem_resp t1, dmem_resp t4 -> WAIT_ID, WAIT_D, RUN at t4; ex_redirect at t2 -> flush at t4, flush_cnt=1.
REQ-030 SHALL cover: ex_redirect and load-use same cycle -> if_id_nop=1, id_ex_nop=1, pc_stall=0; rst during WAIT_D -> RUN, all nops high, counters 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: hazard controller FSM state encoding and
// a helper mapping the outstanding imem/dmem set onto that state.
package rv32i_types;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      WAIT_I  = 2'd1,
      WAIT_D  = 2'd2,
      WAIT_ID = 2'd3
   } hazard_state_t;

   // Outstanding-request set -> state: nothing pending means RUN.
   function automatic hazard_state_t state_from(input logic out_i, input logic out_d);
      hazard_state_t s;
      case ({out_i, out_d})
         2'b10:   s = WAIT_I;
         2'b01:   s = WAIT_D;
         2'b11:   s = WAIT_ID;
         default: s = RUN;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Synchronous active-high reset clears it.
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, load-use bubble and
// redirect flush for a 5-stage RV32I pipeline. All controls are
// combinational from state, redirect_pend and the current inputs.
// A cycle whose response completes the outstanding set is a running cycle
// (no stall); new requests are only tracked while the registered state is RUN.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
// dbg_state exposes the registered FSM state.
module hazard_ctrl
   import rv32i_types::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_redirect,
   input  logic             imem_req,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_nop,
   output logic             id_ex_stall,
   output logic             id_ex_nop,
   output logic             ex_mem_stall,
   output logic             ex_mem_nop,
   output logic             mem_wb_stall,
   output logic             mem_wb_nop,
`ifdef HAZARD_PERF_EN
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] loaduse_cnt,
   output logic [CNT_W-1:0] flush_cnt,
`endif
   output hazard_state_t    dbg_state
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("hazard_ctrl: CNT_W must be at least 1");
   end

   hazard_state_t state_q, state_d;
   logic          redirect_pend_q, redirect_pend_d;
   logic          out_i, out_d, wait_now, flush, load_use, load_use_hit;

   assign load_use_hit = ex_is_load && (ex_rd != 5'd0) &&
                         ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                          (id_uses_rs2 && (id_rs2 == ex_rd)));

   // Next state, pending-redirect tracking and all stall/nop controls.
   always_comb begin
      out_i           = 1'b0;
      out_d           = 1'b0;
      flush           = 1'b0;
      load_use        = 1'b0;
      redirect_pend_d = redirect_pend_q;
      pc_stall        = 1'b0;
      if_id_stall     = 1'b0;
      if_id_nop       = 1'b0;
      id_ex_stall     = 1'b0;
      id_ex_nop       = 1'b0;
      ex_mem_stall    = 1'b0;
      ex_mem_nop      = 1'b0;
      mem_wb_stall    = 1'b0;
      mem_wb_nop      = 1'b0;
      case (state_q)
         RUN: begin
            out_i = imem_req & ~imem_resp;
            out_d = dmem_req & ~dmem_resp;
         end
         WAIT_I:  out_i = ~imem_resp;
         WAIT_D:  out_d = ~dmem_resp;
         WAIT_ID: begin
            out_i = ~imem_resp;
            out_d = ~dmem_resp;
         end
         default: ;
      endcase
      wait_now = out_i | out_d;
      state_d  = state_from(out_i, out_d);
      if (wait_now) begin
         // Freeze everything and bubble WB; remember any redirect for later.
         pc_stall        = 1'b1;
         if_id_stall     = 1'b1;
         id_ex_stall     = 1'b1;
         ex_mem_stall    = 1'b1;
         mem_wb_stall    = 1'b1;
         mem_wb_nop      = 1'b1;
         redirect_pend_d = redirect_pend_q | ex_redirect;
      end else begin
         flush           = ex_redirect | redirect_pend_q;
         load_use        = ~flush & load_use_hit;
         redirect_pend_d = 1'b0;
         if (flush) begin
            if_id_nop = 1'b1;
            id_ex_nop = 1'b1;
         end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_nop   = 1'b1;
         end
      end
      if (rst) begin
         state_d         = RUN;
         redirect_pend_d = 1'b0;
         wait_now        = 1'b0;
         flush           = 1'b0;
         load_use        = 1'b0;
         pc_stall        = 1'b0;
         if_id_stall     = 1'b0;
         id_ex_stall     = 1'b0;
         ex_mem_stall    = 1'b0;
         mem_wb_stall    = 1'b0;
         if_id_nop       = 1'b1;
         id_ex_nop       = 1'b1;
         ex_mem_nop      = 1'b1;
         mem_wb_nop      = 1'b1;
      end
   end

   // State and pending-redirect registers.
   always_ff @(posedge clk) begin
      state_q         <= state_d;
      redirect_pend_q <= redirect_pend_d;
   end

   assign dbg_state = state_q;

`ifdef HAZARD_PERF_EN
   logic stall_inc, lu_inc, flush_inc;
   assign stall_inc = wait_now | load_use;
   assign lu_inc    = load_use;
   assign flush_inc = flush;

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cycles));
   hazard_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
      .clk(clk), .rst(rst), .inc(lu_inc), .count(loaduse_cnt));
   hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .inc(flush_inc), .count(flush_cnt));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random stimulus, each cycle
// predicted by a rule-level model and checked by a scoreboard monitor.
module tb_hazard_ctrl;
   import rv32i_types::*;

   localparam int CNT_W = 8;
   localparam int W     = 9 + 2 + 3 * CNT_W;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect;
   logic imem_req, imem_resp, dmem_req, dmem_resp;
   logic pc_stall, if_id_stall, if_id_nop, id_ex_stall, id_ex_nop;
   logic ex_mem_stall, ex_mem_nop, mem_wb_stall, mem_wb_nop;
   logic [CNT_W-1:0] stall_cycles, loaduse_cnt, flush_cnt;
   hazard_state_t dbg_state;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .imem_req(imem_req), .imem_resp(imem_resp),
      .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_nop(if_id_nop),
      .id_ex_stall(id_ex_stall), .id_ex_nop(id_ex_nop),
      .ex_mem_stall(ex_mem_stall), .ex_mem_nop(ex_mem_nop),
      .mem_wb_stall(mem_wb_stall), .mem_wb_nop(mem_wb_nop),
`ifdef HAZARD_PERF_EN
      .stall_cycles(stall_cycles), .loaduse_cnt(loaduse_cnt), .flush_cnt(flush_cnt),
`endif
      .dbg_state(dbg_state)
   );

`ifndef HAZARD_PERF_EN
   assign stall_cycles = '0;
   assign loaduse_cnt  = '0;
   assign flush_cnt    = '0;
`endif

   // Clock.
   always #5 clk = ~clk;

   // Reference model: which memories are still owed a response, whether a
   // redirect is waiting for the pipeline to move, and event totals.
   logic m_oi, m_od, m_pend;
   int   m_sc, m_lc, m_fc;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [1:0] model_state(input logic oi, input logic od);
      if (oi && od) return WAIT_ID;
      if (oi)       return WAIT_I;
      if (od)       return WAIT_D;
      return RUN;
   endfunction

   function automatic int sat_inc(input int v, input logic hit);
      if (hit && v < SAT) return v + 1;
      return v;
   endfunction

   // Predict this cycle's outputs, push them, advance the model, clock once.
   // Output order: pc_stall, if_id_stall, if_id_nop, id_ex_stall, id_ex_nop,
   // ex_mem_stall, ex_mem_nop, mem_wb_stall, mem_wb_nop.
   task automatic step();
      logic oi_n, od_n, wt, fl, lu, hit;
      logic [8:0] o;
      logic [W-1:0] e;
      logic [23:0] cnts;
`ifdef HAZARD_PERF_EN
      cnts = {m_sc[7:0], m_lc[7:0], m_fc[7:0]};
`else
      cnts = '0;
`endif
      if (rst) begin
         o = 9'b001010101;
         e = {o, model_state(m_oi, m_od), cnts};
         m_oi = 0; m_od = 0; m_pend = 0; m_sc = 0; m_lc = 0; m_fc = 0;
      end else begin
         if (!m_oi && !m_od) begin
            oi_n = imem_req && !imem_resp;
            od_n = dmem_req && !dmem_resp;
         end else begin
            oi_n = m_oi && !imem_resp;
            od_n = m_od && !dmem_resp;
         end
         wt = oi_n || od_n;
         fl = 0; lu = 0;
         if (wt) begin
            o = 9'b110101011;
            m_pend = m_pend || ex_redirect;
         end else begin
            fl  = ex_redirect || m_pend;
            hit = ex_is_load && ex_rd != 0 &&
                  ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
            lu  = !fl && hit;
            o   = fl ? 9'b001010000 : (lu ? 9'b110010000 : 9'b000000000);
            m_pend = 0;
         end
         e = {o, model_state(m_oi, m_od), cnts};
         m_sc = sat_inc(m_sc, wt || lu);
         m_lc = sat_inc(m_lc, lu);
         m_fc = sat_inc(m_fc, fl);
         m_oi = oi_n; m_od = od_n;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_rd = 0; ex_is_load = 0; ex_redirect = 0;
      imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
   endtask

   task automatic reset_cycle();
      idle(); rst = 1; step(); rst = 0;
   endtask

   // Monitor: outputs are valid every cycle; compare at the falling edge.
   always @(negedge clk) begin
      logic [W-1:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pc_stall, if_id_stall, if_id_nop, id_ex_stall, id_ex_nop,
              ex_mem_stall, ex_mem_nop, mem_wb_stall, mem_wb_nop,
              dbg_state, stall_cycles, loaduse_cnt, flush_cnt};
         n_checks++;
         if (a === e) n_pass++;
         else $display("FAIL cycle_check t=%0t outs/state/cnts got %b want %b", $time, a, e);
      end
   end

   initial begin
      int guard;
      m_oi = 0; m_od = 0; m_pend = 0; m_sc = 0; m_lc = 0; m_fc = 0;
      idle(); rst = 1;
      repeat (2) @(posedge clk);
      #1;
      reset_cycle();

      // Load-use on rs1, then back to clean.
      ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; step();
      idle(); step();
      // Load to x0 never stalls.
      ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; step();
      idle(); step();
      reset_cycle();

      // dmem wait of three cycles.
      dmem_req = 1; step(); idle();
      step(); step();
      dmem_resp = 1; step(); idle(); step();
      reset_cycle();

      // Dual wait, imem returns first, redirect while waiting.
      imem_req = 1; dmem_req = 1; step(); idle();
      imem_resp = 1; step(); idle();
      ex_redirect = 1; step(); idle();
      step();
      dmem_resp = 1; step(); idle(); step();

      // Redirect beats load-use in the same cycle.
      ex_redirect = 1; ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1; step();
      idle(); step();
      // Zero-latency completion: no wait.
      imem_req = 1; imem_resp = 1; step(); idle(); step();

      // Reset mid-wait; late response is ignored.
      dmem_req = 1; step(); idle(); step();
      reset_cycle();
      dmem_resp = 1; step(); idle(); step();

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         rst         = ($urandom_range(0, 499) == 0);
         id_rs1      = 5'($urandom_range(0, 7));
         id_rs2      = 5'($urandom_range(0, 7));
         id_uses_rs1 = 1'($urandom_range(0, 1));
         id_uses_rs2 = 1'($urandom_range(0, 1));
         ex_rd       = 5'($urandom_range(0, 7));
         ex_is_load  = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 5) == 0);
         imem_req    = ($urandom_range(0, 3) == 0);
         dmem_req    = ($urandom_range(0, 3) == 0);
         imem_resp   = ($urandom_range(0, 2) == 0);
         dmem_resp   = ($urandom_range(0, 2) == 0);
         step();
      end
      idle();

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      #1;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain left=%0d want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
